// File: rtl/img_rsz_blk_acc.sv
// ============================================================================
// img_rsz_blk_acc
// ----------------------------------------------------------------------------
// Block accumulator for the image resizer. It takes the raster-order source
// pixel stream and sums each colour over every BlkSzHor x BlkSzVer block. Each
// finished block sum goes into a small output FIFO. The FIFO head is offered to
// the compute engine together with one-hot block column and row masks. One
// accumulator row, spanning all output columns, holds the partial sums.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   PxlData/PxlVld/PxlRdy source pixel stream (capture = PxlVld & PxlRdy)
//   IsFstPxl              pixel (0,0) of an image; starts or restarts an image
//   BlkSzHor/BlkSzVer     block size, latched on first-pixel capture (0 -> 1)
//   CompBlkData           per-colour block sums (same packing as PxlData)
//   CompBlkXMsk/YMsk      one-hot block column / row
//   CompBlkVld/CompBlkRdy block handshake towards the compute engine
//   AccImgDone            one-cycle pulse once the last block was accepted
//
// Optional feature (macro IMG_RSZ_ACC_RND_EN): the first pixel of each block
// is preloaded with (BlkSzHor*BlkSzVer)>>1. The downstream truncating divide
// then rounds to nearest.
// ============================================================================
module img_rsz_blk_acc #(
    parameter int RSZ_IMG_WIDTH_SIZE  = 32,
    parameter int RSZ_IMG_HEIGHT_SIZE = 24,
    parameter int PXL_PRIM_COLOR_NUM  = 3,
    parameter int PXL_PRIM_COLOR_W    = 8,
    parameter int BLK_WIDTH_MAX_SZ_W  = 5,
    parameter int BLK_HEIGHT_MAX_SZ_W = 5,
    parameter int BLK_SUM_MAX_W       = PXL_PRIM_COLOR_W + BLK_WIDTH_MAX_SZ_W + BLK_HEIGHT_MAX_SZ_W,
    parameter int OFIFO_DEPTH         = 2
) (
    input  logic                                           Clk,
    input  logic                                           Reset,
    input  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] PxlData,
    input  logic                                           PxlVld,
    output logic                                           PxlRdy,
    input  logic                                           IsFstPxl,
    input  logic [BLK_WIDTH_MAX_SZ_W-1:0]                  BlkSzHor,
    input  logic [BLK_HEIGHT_MAX_SZ_W-1:0]                 BlkSzVer,
    output logic [PXL_PRIM_COLOR_NUM*BLK_SUM_MAX_W-1:0]    CompBlkData,
    output logic [RSZ_IMG_WIDTH_SIZE-1:0]                  CompBlkXMsk,
    output logic [RSZ_IMG_HEIGHT_SIZE-1:0]                 CompBlkYMsk,
    output logic                                           CompBlkVld,
    input  logic                                           CompBlkRdy,
    output logic                                           AccImgDone
);
    localparam int NC    = PXL_PRIM_COLOR_NUM;
    localparam int CW    = PXL_PRIM_COLOR_W;
    localparam int SW    = BLK_SUM_MAX_W;
    localparam int XW    = RSZ_IMG_WIDTH_SIZE;
    localparam int YW    = RSZ_IMG_HEIGHT_SIZE;
    localparam int HW    = BLK_WIDTH_MAX_SZ_W;
    localparam int VW    = BLK_HEIGHT_MAX_SZ_W;
    localparam int BX_W  = (XW > 1) ? $clog2(XW) : 1;
    localparam int BY_W  = (YW > 1) ? $clog2(YW) : 1;
    localparam int FA_W  = $clog2(OFIFO_DEPTH);
    localparam int PW    = FA_W + 1;
    localparam int ENT_W = NC*SW + XW + YW;
    localparam logic [BX_W-1:0] BX_LAST = BX_W'(XW - 1);
    localparam logic [BY_W-1:0] BY_LAST = BY_W'(YW - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DRAIN} state_t;

    state_t                        state_q, state_d;
    logic                          run_q, run_d;
    logic [HW-1:0]                 hor_q, hor_d;
    logic [VW-1:0]                 ver_q, ver_d;
    logic [HW-1:0]                 col_q, col_d;
    logic [BX_W-1:0]               bx_q, bx_d;
    logic [VW-1:0]                 line_q, line_d;
    logic [BY_W-1:0]               by_q, by_d;
    logic [XW-1:0][NC-1:0][SW-1:0] acc_q, acc_d;
    logic [OFIFO_DEPTH-1:0][ENT_W-1:0] mem_q, mem_d;
    logic [PW-1:0]                 wptr_q, wptr_d, rptr_q, rptr_d;

    logic                  fifo_full, fifo_empty;
    logic                  capture, start, proc, push, pop;
    logic [HW-1:0]         eff_hor, base_col;
    logic [VW-1:0]         eff_ver, base_line;
    logic [BX_W-1:0]       base_bx;
    logic [BY_W-1:0]       base_by;
    logic                  col_end, line_end, bx_end, by_end;
    logic                  first_px, blk_done, img_last;
    logic [SW-1:0]         bias;
    logic [NC-1:0][SW-1:0] blk_sum;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[FA_W] != rptr_q[FA_W]) &&
                        (wptr_q[FA_W-1:0] == rptr_q[FA_W-1:0]);
    assign capture    = PxlVld & PxlRdy;
    assign start      = capture & IsFstPxl;
    // Captures in IDLE without IsFstPxl are swallowed.
    assign proc       = start | (capture & (state_q == ST_ACC));
    assign pop        = CompBlkVld & CompBlkRdy;
    assign CompBlkVld = !fifo_empty;
    assign {CompBlkData, CompBlkXMsk, CompBlkYMsk} = mem_q[rptr_q[FA_W-1:0]];

    // Effective position/size of the pixel being captured. A first pixel is
    // processed as (0,0) with its own (clamped) sizes, before they land in the
    // size registers.
    always_comb begin
        eff_hor   = hor_q;
        eff_ver   = ver_q;
        base_col  = col_q;
        base_bx   = bx_q;
        base_line = line_q;
        base_by   = by_q;
        if (start) begin
            eff_hor   = (BlkSzHor == '0) ? HW'(1) : BlkSzHor;
            eff_ver   = (BlkSzVer == '0) ? VW'(1) : BlkSzVer;
            base_col  = '0;
            base_bx   = '0;
            base_line = '0;
            base_by   = '0;
        end
    end

`ifdef IMG_RSZ_ACC_RND_EN
    logic [SW-1:0] bias_q, bias_d;

    // Half the block area, computed once per image. The first pixel uses it
    // directly, before bias_q is loaded.
    always_comb begin
        bias_d = bias_q;
        if (start) bias_d = (SW'(eff_hor) * SW'(eff_ver)) >> 1;
        bias = bias_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) bias_q <= '0;
        else       bias_q <= bias_d;
    end
`else
    assign bias = '0;
`endif

    // Counters, accumulator row and FIFO.
    always_comb begin
        col_end  = (base_col == eff_hor - HW'(1));
        line_end = (base_line == eff_ver - VW'(1));
        bx_end   = (base_bx == BX_LAST);
        by_end   = (base_by == BY_LAST);
        first_px = (base_col == '0) && (base_line == '0);
        blk_done = col_end & line_end;
        img_last = blk_done & bx_end & by_end;
        push     = proc & blk_done;

        hor_d  = start ? eff_hor : hor_q;
        ver_d  = start ? eff_ver : ver_q;
        col_d  = col_q;
        bx_d   = bx_q;
        line_d = line_q;
        by_d   = by_q;
        if (proc) begin
            col_d  = col_end ? '0 : base_col + HW'(1);
            bx_d   = base_bx;
            line_d = base_line;
            by_d   = base_by;
            if (col_end) begin
                bx_d = bx_end ? '0 : base_bx + BX_W'(1);
                if (bx_end) begin
                    line_d = line_end ? '0 : base_line + VW'(1);
                    if (line_end) by_d = by_end ? '0 : base_by + BY_W'(1);
                end
            end
        end

        // The first pixel of a block overwrites the slot, so no clear pass is needed.
        blk_sum = '0;
        for (int c = 0; c < NC; c++) begin
            blk_sum[c] = first_px ? SW'(PxlData[c*CW +: CW]) + bias
                                  : acc_q[base_bx][c] + SW'(PxlData[c*CW +: CW]);
        end
        acc_d = acc_q;
        if (proc) acc_d[base_bx] = blk_sum;

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q[FA_W-1:0]] = {blk_sum, XW'(1) << base_bx, YW'(1) << base_by};
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (proc) state_d = img_last ? ST_DRAIN : ST_ACC;
            ST_ACC:   if (proc && img_last) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. run_q keeps PxlRdy low for the first cycle out of reset.
    always_comb begin
        run_d      = 1'b1;
        PxlRdy     = 1'b0;
        AccImgDone = 1'b0;
        case (state_q)
            ST_IDLE:  PxlRdy = run_q;
            ST_ACC:   PxlRdy = !fifo_full;
            ST_DRAIN: AccImgDone = fifo_empty;
            default:  PxlRdy = 1'b0;
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            hor_q   <= '0;
            ver_q   <= '0;
            col_q   <= '0;
            bx_q    <= '0;
            line_q  <= '0;
            by_q    <= '0;
            acc_q   <= '0;
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            hor_q   <= hor_d;
            ver_q   <= ver_d;
            col_q   <= col_d;
            bx_q    <= bx_d;
            line_q  <= line_d;
            by_q    <= by_d;
            acc_q   <= acc_d;
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end
endmodule

// File: tb/tb_img_rsz_blk_acc.sv
// Directed bench for img_rsz_blk_acc: 4 x 1 output blocks, 2-entry FIFO.
module tb_img_rsz_blk_acc;
    localparam int XW = 4;
    localparam int YW = 1;
    localparam int SW = 18;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [23:0]   PxlData;
    logic          PxlVld, PxlRdy, IsFstPxl;
    logic [4:0]    BlkSzHor, BlkSzVer;
    logic [3*SW-1:0] CompBlkData;
    logic [XW-1:0] CompBlkXMsk;
    logic [YW-1:0] CompBlkYMsk;
    logic          CompBlkVld, CompBlkRdy, AccImgDone;

    always #5 Clk = ~Clk;

    img_rsz_blk_acc #(
        .RSZ_IMG_WIDTH_SIZE(XW), .RSZ_IMG_HEIGHT_SIZE(YW), .OFIFO_DEPTH(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .PxlData(PxlData), .PxlVld(PxlVld), .PxlRdy(PxlRdy),
        .IsFstPxl(IsFstPxl), .BlkSzHor(BlkSzHor), .BlkSzVer(BlkSzVer),
        .CompBlkData(CompBlkData), .CompBlkXMsk(CompBlkXMsk), .CompBlkYMsk(CompBlkYMsk),
        .CompBlkVld(CompBlkVld), .CompBlkRdy(CompBlkRdy), .AccImgDone(AccImgDone)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [3*SW-1:0] q_data[$];
    logic [XW-1:0]   q_x[$];
    logic [YW-1:0]   q_y[$];

    // Record every accepted block; the handshake completes on the next rising edge.
    always @(negedge Clk) begin
        if (!Reset && CompBlkVld && CompBlkRdy) begin
            q_data.push_back(CompBlkData);
            q_x.push_back(CompBlkXMsk);
            q_y.push_back(CompBlkYMsk);
        end
        if (AccImgDone) done_cnt++;
    end

    function automatic logic [23:0] px(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [23:0] d, input logic fst);
        int n = 0;
        PxlData = d; PxlVld = 1'b1; IsFstPxl = fst;
        while (!PxlRdy && n < 200) begin
            @(posedge Clk); #1; n++;
        end
        chk("send_ready", 64'(n < 200), 64'd1);
        @(posedge Clk); #1;
        PxlVld = 1'b0; IsFstPxl = 1'b0;
    endtask

    task automatic clear_q();
        q_data.delete(); q_x.delete(); q_y.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(posedge Clk); #1; n++;
        end
        repeat (3) @(posedge Clk);
        #1;
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({tag, "_idle_rdy"}, 64'(PxlRdy), 64'd1);
    endtask

    task automatic chk_blk(input string tag, input logic [SW-1:0] e0, input logic [SW-1:0] e1,
                           input logic [SW-1:0] e2, input logic [XW-1:0] ex);
        logic [3*SW-1:0] d;
        chk({tag, "_avail"}, 64'(q_data.size() != 0), 64'd1);
        if (q_data.size() != 0) begin
            d = q_data.pop_front();
            chk({tag, "_c0"}, 64'(d[SW-1:0]), 64'(e0));
            chk({tag, "_c1"}, 64'(d[2*SW-1:SW]), 64'(e1));
            chk({tag, "_c2"}, 64'(d[3*SW-1:2*SW]), 64'(e2));
            chk({tag, "_xmsk"}, 64'(q_x.pop_front()), 64'(ex));
            chk({tag, "_ymsk"}, 64'(q_y.pop_front()), 64'd1);
        end
    endtask

    initial begin
        Reset = 1'b1; PxlData = '0; PxlVld = 1'b0; IsFstPxl = 1'b0;
        BlkSzHor = '0; BlkSzVer = '0; CompBlkRdy = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_pxlrdy", 64'(PxlRdy), 64'd0);
        chk("rst_vld", 64'(CompBlkVld), 64'd0);
        chk("rst_done", 64'(AccImgDone), 64'd0);
        chk("rst_data", 64'(CompBlkData), 64'd0);
        chk("rst_xmsk", 64'(CompBlkXMsk), 64'd0);
        chk("rst_ymsk", 64'(CompBlkYMsk), 64'd0);
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("idle_pxlrdy", 64'(PxlRdy), 64'd1);

        // 2x2 blocks, constant pixel: colour sums 40 / 4 / 0.
        clear_q(); CompBlkRdy = 1'b1; BlkSzHor = 5'd2; BlkSzVer = 5'd2;
        for (int i = 0; i < 16; i++) send(px(8'd10, 8'd1, 8'd0), i == 0);
        wait_done("t1");
        for (int b = 0; b < 4; b++) chk_blk($sformatf("t1_b%0d", b), 18'd40, 18'd4, 18'd0, 4'(1 << b));

        // 2x2 blocks, raster ramp 1..16 in colour 0: sums 22, 30, 38, 46.
        clear_q();
        for (int i = 0; i < 16; i++) send(px(8'(i + 1), 8'd0, 8'd255), i == 0);
        wait_done("t2");
        chk_blk("t2_b0", 18'd22, 18'd0, 18'd1020, 4'b0001);
        chk_blk("t2_b1", 18'd30, 18'd0, 18'd1020, 4'b0010);
        chk_blk("t2_b2", 18'd38, 18'd0, 18'd1020, 4'b0100);
        chk_blk("t2_b3", 18'd46, 18'd0, 18'd1020, 4'b1000);

        // Backpressure: 1x1 blocks, FIFO fills after two pushes, head held.
        clear_q(); CompBlkRdy = 1'b0; BlkSzHor = 5'd1; BlkSzVer = 5'd1;
        send(px(8'd5, 8'd0, 8'd0), 1'b1);
        send(px(8'd6, 8'd0, 8'd0), 1'b0);
        chk("t3_full_rdy", 64'(PxlRdy), 64'd0);
        chk("t3_vld", 64'(CompBlkVld), 64'd1);
        chk("t3_head", 64'(CompBlkData[SW-1:0]), 64'd5);
        repeat (3) @(posedge Clk);
        #1;
        chk("t3_hold_rdy", 64'(PxlRdy), 64'd0);
        chk("t3_hold_head", 64'(CompBlkData[SW-1:0]), 64'd5);
        chk("t3_hold_xmsk", 64'(CompBlkXMsk), 64'b0001);
        CompBlkRdy = 1'b1;
        send(px(8'd7, 8'd0, 8'd0), 1'b0);
        send(px(8'd8, 8'd0, 8'd0), 1'b0);
        wait_done("t3");
        for (int b = 0; b < 4; b++) chk_blk($sformatf("t3_b%0d", b), 18'(5 + b), 18'd0, 18'd0, 4'(1 << b));

        // Pixels in IDLE without IsFstPxl are dropped; zero sizes clamp to 1x1.
        clear_q(); BlkSzHor = 5'd3; BlkSzVer = 5'd3;
        for (int i = 0; i < 3; i++) send(px(8'd99, 8'd0, 8'd0), 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        chk("t4_no_vld", 64'(CompBlkVld), 64'd0);
        chk("t4_no_push", 64'(q_data.size()), 64'd0);
        BlkSzHor = 5'd0; BlkSzVer = 5'd0;
        send(px(8'd11, 8'd0, 8'd0), 1'b1);
        BlkSzHor = 5'd3; BlkSzVer = 5'd3;   // not sampled mid-image
        for (int i = 1; i < 4; i++) send(px(8'(11 + i), 8'd0, 8'd0), 1'b0);
        wait_done("t4");
        for (int b = 0; b < 4; b++) chk_blk($sformatf("t4_b%0d", b), 18'(11 + b), 18'd0, 18'd0, 4'(1 << b));

        // Restart mid-image: the completed 2x1 block survives, new image is 1x1.
        clear_q(); BlkSzHor = 5'd2; BlkSzVer = 5'd1;
        send(px(8'd3, 8'd0, 8'd0), 1'b1);
        send(px(8'd4, 8'd0, 8'd0), 1'b0);
        send(px(8'd50, 8'd0, 8'd0), 1'b0);
        BlkSzHor = 5'd1; BlkSzVer = 5'd1;
        send(px(8'd20, 8'd0, 8'd0), 1'b1);
        for (int i = 1; i < 4; i++) send(px(8'(20 + i), 8'd0, 8'd0), 1'b0);
        wait_done("t5");
        chk_blk("t5_old", 18'd7, 18'd0, 18'd0, 4'b0001);
        for (int b = 0; b < 4; b++) chk_blk($sformatf("t5_b%0d", b), 18'(20 + b), 18'd0, 18'd0, 4'(1 << b));

        // 3x3 blocks of ones/twos: 9/18/0, plus bias 4 when rounding is built in.
        clear_q(); BlkSzHor = 5'd3; BlkSzVer = 5'd3;
        for (int i = 0; i < 36; i++) send(px(8'd1, 8'd2, 8'd0), i == 0);
        wait_done("t6");
`ifdef IMG_RSZ_ACC_RND_EN
        for (int b = 0; b < 4; b++) chk_blk($sformatf("t6_b%0d", b), 18'd13, 18'd22, 18'd4, 4'(1 << b));
`else
        for (int b = 0; b < 4; b++) chk_blk($sformatf("t6_b%0d", b), 18'd9, 18'd18, 18'd0, 4'(1 << b));
`endif

        // Reset mid-ACC with a block waiting in the FIFO.
        clear_q(); CompBlkRdy = 1'b0; BlkSzHor = 5'd2; BlkSzVer = 5'd2;
        for (int i = 0; i < 10; i++) send(px(8'd1, 8'd0, 8'd0), i == 0);
        chk("t7_pre_vld", 64'(CompBlkVld), 64'd1);
        chk("t7_pre_sum", 64'(CompBlkData[SW-1:0]), 64'd4);
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("t7_rst_vld", 64'(CompBlkVld), 64'd0);
        chk("t7_rst_rdy", 64'(PxlRdy), 64'd0);
        chk("t7_rst_data", 64'(CompBlkData), 64'd0);
        Reset = 1'b0; CompBlkRdy = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("t7_no_blk", 64'(q_data.size()), 64'd0);
        chk("t7_idle_rdy", 64'(PxlRdy), 64'd1);
        BlkSzHor = 5'd1; BlkSzVer = 5'd1;
        for (int i = 0; i < 4; i++) send(px(8'(31 + i), 8'd0, 8'd0), i == 0);
        wait_done("t7");
        for (int b = 0; b < 4; b++) chk_blk($sformatf("t7_b%0d", b), 18'(31 + b), 18'd0, 18'd0, 4'(1 << b));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
